// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail/count bookkeeping for a circular reorder buffer of arbitrary size
module rob_ptr_ctrl #(
  parameter int ROB_SIZE       = 40,
  parameter int ROB_SIZE_WIDTH = 6,
  parameter int ALLOC_W        = 2,
  parameter int RETIRE_W       = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(ALLOC_W+1)-1:0]     alloc_req,
  output logic                             alloc_ack,
  output logic [ROB_SIZE_WIDTH-1:0]        alloc_base,
  input  logic [$clog2(RETIRE_W+1)-1:0]    retire_req,
  output logic                             retire_err,
  input  logic                             flush,
  input  logic [ROB_SIZE_WIDTH-1:0]        flush_tail,
  output logic [ROB_SIZE_WIDTH-1:0]        head,
  output logic [ROB_SIZE_WIDTH-1:0]        tail,
  output logic [ROB_SIZE_WIDTH:0]          count,
  output logic                             full,
  output logic                             empty
);
  localparam int W = ROB_SIZE_WIDTH;
  localparam logic [W:0] SIZE = (W+1)'(ROB_SIZE);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [W:0]   count_q, count_d, free, ar, rr, cnt_ret;
  logic         retire_err_q, retire_err_d, ret_ok;
  // advance a pointer by n, folding back into 0..ROB_SIZE-1 (n never exceeds ROB_SIZE)
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] p, input logic [W:0] n);
    logic [W:0] s;
    s = {1'b0, p} + n;
    return (s >= SIZE) ? W'(s - SIZE) : W'(s);
  endfunction
  // next-state: retire moves head, flush overrides alloc on tail and recomputes count from head_d
  always_comb begin
    free         = SIZE - count_q;
    ar           = (W+1)'(alloc_req);
    rr           = (W+1)'(retire_req);
    alloc_ack    = reset && (alloc_req != '0) && (ar <= free) && !flush;
    ret_ok       = rr <= count_q;
    head_d       = ret_ok ? wrap_add(head_q, rr) : head_q;
    cnt_ret      = ret_ok ? count_q - rr : count_q;
    tail_d       = flush ? flush_tail : alloc_ack ? wrap_add(tail_q, ar) : tail_q;
    count_d      = flush ? (W+1)'(flush_tail) - (W+1)'(head_d) + ((flush_tail < head_d) ? SIZE : '0)
                         : cnt_ret + (alloc_ack ? ar : '0);
    retire_err_d = !ret_ok;
  end
  // state registers, cleared asynchronously by active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      retire_err_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      retire_err_q <= retire_err_d;
    end
  end
  assign head       = head_q;
  assign tail       = tail_q;
  assign count      = count_q;
  assign alloc_base = tail_q;
  assign retire_err = retire_err_q;
  assign full       = count_q == SIZE;
  assign empty      = count_q == '0;
endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// tb_rob_ptr_ctrl: directed scoreboard bench for rob_ptr_ctrl against a modulo-arithmetic model
module tb_rob_ptr_ctrl;
  localparam int SIZE = 40;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] alloc_req = '0, retire_req = '0;
  logic       flush = 1'b0;
  logic [5:0] flush_tail = '0;
  logic       alloc_ack, retire_err, full, empty;
  logic [5:0] alloc_base, head, tail;
  logic [6:0] count;
  int checks = 0, errors = 0;
  int m_head = 0, m_tail = 0, m_count = 0;
  typedef struct {int h; int t; int c; int err;} exp_t;
  exp_t q[$];

  rob_ptr_ctrl dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ack(alloc_ack),
    .alloc_base(alloc_base), .retire_req(retire_req), .retire_err(retire_err),
    .flush(flush), .flush_tail(flush_tail), .head(head), .tail(tail),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int ar, input int rr, input bit fl = 0, input int ft = 0);
    exp_t e;
    bit ack, ok;
    @(negedge clk);
    alloc_req = 2'(ar); retire_req = 2'(rr); flush = fl; flush_tail = 6'(ft);
    #1;
    ack = ar != 0 && ar <= SIZE - m_count && !fl;
    ok  = rr <= m_count;
    chk("alloc_ack", alloc_ack, ack);
    chk("alloc_base", alloc_base, m_tail);
    e.h = ok ? (m_head + rr) % SIZE : m_head;
    if (fl) begin
      e.t = ft;
      e.c = (ft - e.h + SIZE) % SIZE;
    end else begin
      e.t = ack ? (m_tail + ar) % SIZE : m_tail;
      e.c = m_count - (ok ? rr : 0) + (ack ? ar : 0);
    end
    e.err = !ok;
    q.push_back(e);
    m_head = e.h; m_tail = e.t; m_count = e.c;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("head", head, e.h);
    chk("tail", tail, e.t);
    chk("count", count, e.c);
    chk("full", full, e.c == SIZE);
    chk("empty", empty, e.c == 0);
    chk("retire_err", retire_err, e.err);
    alloc_req = '0; retire_req = '0; flush = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_head = 0; m_tail = 0; m_count = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_head", head, 0);
    chk("rst_tail", tail, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ack", alloc_ack, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) step(2, 0);
    chk("fill_tail", tail, 0);
    chk("fill_count", count, 40);
    chk("fill_full", full, 1);
    step(2, 0);
    chk("over_count", count, 40);
    for (int i = 0; i < 19; i++) step(0, 2);
    step(2, 0);
    chk("wrap_head", head, 38);
    chk("wrap_tail", tail, 2);
    step(0, 2);
    chk("ret_wrap_head", head, 0);
    step(0, 2);
    chk("ret_empty", empty, 1);
    chk("ret_head", head, 2);
    for (int i = 0; i < 19; i++) step(2, 0);
    step(1, 0);
    chk("c39", count, 39);
    step(2, 2);
    chk("no_free_count", count, 37);
    step(2, 0);
    chk("realloc_count", count, 39);
    for (int i = 0; i < 19; i++) step(0, 2);
    chk("c1", count, 1);
    step(0, 2);
    chk("bad_ret_count", count, 1);
    chk("bad_ret_err", retire_err, 1);
    step(0, 0);
    chk("err_pulse_end", retire_err, 0);
    step(1, 1);
    do_reset();
    for (int i = 0; i < 10; i++) step(2, 0);
    for (int i = 0; i < 5; i++) step(0, 2);
    step(2, 1, 1, 15);
    chk("fl_head", head, 11);
    chk("fl_tail", tail, 15);
    chk("fl_count", count, 4);
    step(0, 0, 1, 11);
    chk("fl_empty", empty, 1);
    for (int i = 0; i < 8; i++) step(2, 0);
    step(1, 0);
    chk("c17", count, 17);
    @(negedge clk);
    alloc_req = 2'd2;
    #2 reset = 1'b0;
    #1;
    chk("async_head", head, 0);
    chk("async_tail", tail, 0);
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_ack", alloc_ack, 0);
    @(posedge clk);
    #1;
    chk("hold_count", count, 0);
    chk("hold_tail", tail, 0);
    @(negedge clk);
    alloc_req = '0;
    reset = 1'b1;
    m_head = 0; m_tail = 0; m_count = 0;
    step(2, 0);
    chk("post_rst_tail", tail, 2);
    chk("pending_q", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_ptr_ctrl.md
ROB_PTR_CTRL -- requirements
Module: rob_ptr_ctrl

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 40, number of ROB entries (2..2^ROB_SIZE_WIDTH, need not be a power of two).
REQ-002 SHALL have parameter ROB_SIZE_WIDTH, default 6, pointer width.
REQ-003 SHALL have parameter ALLOC_W, default 2, max entries allocated per cycle.
REQ-004 SHALL have parameter RETIRE_W, default 2, max entries retired per cycle.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port alloc_req  input  $clog2(ALLOC_W+1)  number of entries requested this cycle (0..ALLOC_W).
REQ-008 SHALL have port alloc_ack  output  1  request accepted this cycle (combinational).
REQ-009 SHALL have port alloc_base  output  ROB_SIZE_WIDTH  index of first allocated entry, equal to tail.
REQ-010 SHALL have port retire_req  input  $clog2(RETIRE_W+1)  number of oldest entries retiring this cycle.
REQ-011 SHALL have port retire_err  output  1  registered one-cycle pulse, illegal retire request.
REQ-012 SHALL have port flush  input  1  squash entries from flush_tail to tail.
REQ-013 SHALL have port flush_tail  input  ROB_SIZE_WIDTH  new tail after flush.
REQ-014 SHALL have ports head, tail  output  ROB_SIZE_WIDTH each  oldest entry index, next free index.
REQ-015 SHALL have port count  output  ROB_SIZE_WIDTH+1  valid entries (0..ROB_SIZE).
REQ-016 SHALL have ports full, empty  output  1 each  count==ROB_SIZE, count==0.

Function
REQ-017 Pointer arithmetic SHALL be modulo ROB_SIZE: p+n >= ROB_SIZE wraps to p+n-ROB_SIZE; no illegal index ever appears on head or tail.
REQ-018 free = ROB_SIZE - count SHALL be computed from registered count only; same-cycle retire does not free space for same-cycle alloc.
REQ-019 alloc_ack SHALL be 1 iff alloc_req != 0, alloc_req <= free, and flush == 0.
REQ-020 On alloc_ack, next edge: tail <= tail + alloc_req (mod), count += alloc_req; entries alloc_base..alloc_base+alloc_req-1 (mod) belong to the requester.
REQ-021 Retire legal iff retire_req <= count; if legal: head <= head + retire_req (mod), count -= retire_req.
REQ-022 Illegal retire SHALL leave head/count unchanged by the retire term and pulse retire_err the next cycle.
REQ-023 Simultaneous accepted alloc and legal retire SHALL both apply: count_next = count + alloc_req - retire_req.
REQ-024 Flush SHALL take priority over alloc (alloc_ack forced 0); tail <= flush_tail; count <= (flush_tail - head_next) mod ROB_SIZE, head_next including any same-cycle legal retire.
REQ-025 flush_tail SHALL be within [head_next, tail] circularly; flush_tail == head_next yields empty (count 0), never full; out-of-range flush_tail is a caller error, behaviour undefined.
REQ-026 Single-cycle latency: all state updates visible on outputs the cycle after the request edge; full/empty/free derive combinationally from registered count.
REQ-027 With alloc_req==0, retire_req==0, flush==0, all state SHALL hold.

Reset
REQ-028 reset low SHALL asynchronously force head=0, tail=0, count=0, retire_err=0, hence empty=1, full=0, alloc_ack=0; release synchronous to next clk edge.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight requests; first accepted request after release starts at index 0.

Verification
REQ-030 Reset release, alloc_req=2 for 20 cycles -> tail 0,2,..,38,0; count 40; full=1; 21st request alloc_ack=0, state unchanged.
REQ-031 head=38, tail=2, count=4; retire_req=2 -> head=0, count=2; retire_req=2 again -> head=2, count=0, empty=1.
REQ-032 count=39 (free=1), alloc_req=2 with retire_req=2 same cycle -> alloc_ack=0, count=37; next cycle alloc_req=2 -> ack=1, count=39.
REQ-033 count=1, retire_req=2 -> head/count unchanged, retire_err=1 exactly one cycle later.
REQ-034 head=10, tail=20, flush=1, flush_tail=15, alloc_req=2, retire_req=1 -> alloc_ack=0, head=11, tail=15, count=4; flush_tail=11 next -> count=0, empty=1.
REQ-035 Reset pulsed low between clock edges while count=17 -> outputs zero immediately, without clk edge; held through next edge.
